// File: rtl/sum_3.sv
// Sliding three-sample window: registered signed sum of the newest three samples
// and that sum divided by three (truncated toward zero), plus a window-full flag.
module sum_3 #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [WIDTH-1:0]  num,
    output logic signed [WIDTH+1:0]  sum,
    output logic signed [WIDTH-1:0]  avg,
    output logic                     full
);

    // Reciprocal of 3 scaled by 2^(WIDTH+2), rounded up; exact for magnitudes below 2^(WIDTH+1).
    localparam logic [WIDTH+2:0] RECIP =
        ({1'b1, {(WIDTH+2){1'b0}}} / (WIDTH+3)'(3)) + (WIDTH+3)'(1);

    logic signed [WIDTH-1:0]  r_s0;
    logic signed [WIDTH-1:0]  r_s1;
    logic signed [WIDTH-1:0]  r_s2;
    logic        [1:0]        r_count;
    logic signed [WIDTH+1:0]  r_sum;
    logic signed [WIDTH-1:0]  r_avg;
    logic                     r_full;

    logic signed [WIDTH+1:0]  w_sum;
    logic                     w_neg;
    logic        [WIDTH+1:0]  w_mag;
    logic        [2*WIDTH+3:0] w_prod;
    logic        [WIDTH-1:0]  w_quot;
    logic        [WIDTH-1:0]  w_avg;
    logic                     w_unusedBits;

    assign w_sum = {{2{num[WIDTH-1]}},  num}
                 + {{2{r_s0[WIDTH-1]}}, r_s0}
                 + {{2{r_s1[WIDTH-1]}}, r_s1};

    // Divide the magnitude, then restore the sign, so the quotient truncates toward zero.
    assign w_neg  = w_sum[WIDTH+1];
    assign w_mag  = w_neg ? ((WIDTH+2)'(0) - w_sum) : w_sum;
    assign w_prod = {{(WIDTH+3){1'b0}}, w_mag[WIDTH:0]} * {{(WIDTH+1){1'b0}}, RECIP};
    assign w_quot = w_prod[2*WIDTH+1:WIDTH+2];
    assign w_avg  = w_neg ? (WIDTH'(0) - w_quot) : w_quot;

    // s2 completes the history but never feeds the window, which reads num, s0 and s1.
    assign w_unusedBits = ^{r_s2, w_prod[2*WIDTH+3:2*WIDTH+2], w_prod[WIDTH+1:0], w_mag[WIDTH+1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s0    <= '0;
            r_s1    <= '0;
            r_s2    <= '0;
            r_count <= '0;
            r_sum   <= '0;
            r_avg   <= '0;
            r_full  <= 1'b0;
        end else begin
            r_s0  <= num;
            r_s1  <= r_s0;
            r_s2  <= r_s1;
            r_sum <= w_sum;
            r_avg <= w_avg;
            if (r_count != 2'd3) begin
                r_count <= r_count + 2'd1;
            end
            r_full <= (r_count >= 2'd2);
        end
    end

    assign sum  = r_sum;
    assign avg  = r_avg;
    assign full = r_full;

endmodule

// File: tb/tb_sum_3.sv
// Randomized and directed bench for sum_3 against a queue-based window model.
module tb_sum_3;

    localparam int WIDTH = 8;

    logic                    clk;
    logic                    rst;
    logic signed [WIDTH-1:0] num;
    logic signed [WIDTH+1:0] sum;
    logic signed [WIDTH-1:0] avg;
    logic                    full;

    int checkCount;
    int failCount;
    int window[$];
    int filled;

    sum_3 #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .num  (num),
        .sum  (sum),
        .avg  (avg),
        .full (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // One clock edge with the given inputs; the model tracks the newest three samples.
    task automatic applyStimulus(input logic r, input int n);
        int expSum;
        rst = r;
        num = WIDTH'(n);
        @(posedge clk);
        if (r) begin
            window.delete();
            filled = 0;
        end else begin
            window.push_front(int'(num));
            if (window.size() > 3) void'(window.pop_back());
            if (filled < 3) filled++;
        end
        expSum = 0;
        foreach (window[i]) expSum += window[i];
        #1;
        checkOutput("sum", int'(sum), expSum);
        checkOutput("avg", int'(avg), expSum / 3);
        checkOutput("full", int'(full), (filled == 3) ? 1 : 0);
    endtask

    task automatic directed(input logic r, input int n, input int eSum, input int eAvg, input int eFull);
        applyStimulus(r, n);
        checkOutput("dirSum", int'(sum), eSum);
        checkOutput("dirAvg", int'(avg), eAvg);
        checkOutput("dirFull", int'(full), eFull);
    endtask

    initial begin
        checkCount = 0;
        failCount  = 0;
        filled     = 0;
        rst = 1'b1;
        num = '0;

        directed(1, 0, 0, 0, 0);
        directed(1, 0, 0, 0, 0);
        directed(0, 2, 2, 0, 0);
        directed(0, 1, 3, 1, 0);
        directed(0, -1, 2, 0, 1);
        directed(0, -1, -1, 0, 1);
        directed(0, -1, -3, -1, 1);
        directed(0, -1, -3, -1, 1);

        directed(1, 0, 0, 0, 0);
        directed(0, 127, 127, 42, 0);
        directed(0, 127, 254, 84, 0);
        directed(0, 127, 381, 127, 1);
        directed(0, -128, 126, 42, 1);
        directed(0, -128, -129, -43, 1);
        directed(0, -128, -384, -128, 1);

        directed(0, -2, -258, -86, 1);
        directed(0, -2, -132, -44, 1);
        directed(0, -1, -5, -1, 1);

        directed(1, 50, 0, 0, 0);
        directed(0, 9, 9, 3, 0);
        directed(0, 5, 14, 4, 0);
        directed(0, 5, 19, 6, 1);

        for (int i = 0; i < 20; i++) begin
            directed(1, int'($urandom_range(255)) - 128, 0, 0, 0);
        end

        for (int i = 0; i < 300; i++) begin
            applyStimulus(($urandom_range(19) == 0), int'($urandom_range(255)) - 128);
        end

        for (int i = 0; i < 4; i++) applyStimulus(0, 127);
        for (int i = 0; i < 4; i++) applyStimulus(0, -128);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/sum_3.md
SUM_3 -- requirements
Module: sum_3

Interface
REQ-001 Parameter WIDTH, default 8, sample width in bits (two's complement).
REQ-002 clk  input  1  rising-edge clock; all state updates on this edge only.
REQ-003 rst  input  1  synchronous, active-high reset; sampled on rising edge of clk.
REQ-004 num  input  WIDTH  signed input sample, captured every clock edge (no valid strobe).
REQ-005 sum  output  WIDTH+2  signed, registered sum of last three captured samples.
REQ-006 avg  output  WIDTH  signed, registered sum/3, truncated toward zero.
REQ-007 full  output  1  registered; high once three samples captured since reset.

Function
REQ-008 Block SHALL hold a 3-deep sample history s0 (newest), s1, s2, each WIDTH bits signed.
REQ-009 On each non-reset edge: s0<=num, s1<=s0, s2<=s1.
REQ-010 On the same edge: sum <= sign-extended (num + s0 + s1), i.e. sum includes the sample captured at that edge; latency 1 clock from num to sum.
REQ-011 All additions SHALL be performed at WIDTH+2 bits with sign extension; no overflow possible (range -3*2^(WIDTH-1) .. 3*(2^(WIDTH-1)-1)).
REQ-012 avg SHALL update on the same edge as sum, equal to (num + s0 + s1)/3 with truncation toward zero (e.g. -5 -> -1, 5 -> 1); result always fits WIDTH bits signed.
REQ-013 Division by 3 SHALL be constant-divisor logic (no iterative divider); avg never lags sum.
REQ-014 Fill counter (2 bits) SHALL increment per non-reset edge, saturating at 3; full = (count == 3).
REQ-015 Before full, missing history entries SHALL contribute zero (they hold reset value 0), so sum/avg are partial-window values.
REQ-016 Constant input x held >= 3 cycles SHALL yield sum = 3x, avg = x.
REQ-017 Inputs are consumed every cycle; no stall, no back-pressure, no X-propagation from unused history (history always defined).

Reset
REQ-018 While rst high at a rising edge: s0, s1, s2, sum, avg, count SHALL all be cleared to 0; full = 0.
REQ-019 num is ignored on edges where rst is high; first sample captured is on first edge with rst low.
REQ-020 Reset asserted mid-stream SHALL discard all history; subsequent sums restart from partial window (REQ-015).
REQ-021 Held reset (rst high indefinitely) SHALL keep all outputs at 0.

Verification
REQ-022 rst high 2 edges, then num = 2, 1, -1 on successive edges -> sum = 2, 3, 2; avg = 0, 1, 0; full = 0, 0, 1.
REQ-023 Continue holding num = -1 -> next edges sum = -1, then -3, -3; avg = 0, -1, -1; full stays 1.
REQ-024 num = 127 x3 -> sum = 381, avg = 127; then num = -128 x3 -> sum = 126, -129, -384; avg = 42, -43, -128.
REQ-025 num = -2, -2, -1 -> sum = -5 after third edge, avg = -1 (truncation toward zero).
REQ-026 After full, assert rst for 1 edge mid-stream with num = 50 -> sum = avg = 0, full = 0; next num = 9 -> sum = 9, avg = 3, full = 0.
REQ-027 Hold rst high with random num for 20 edges -> sum, avg, full remain 0 every cycle.
